// File: rtl/sint_pkg.sv
// sint_pkg: shared definitions for the signed streaming fixtures.
//   state_e        - accumulator FSM state (ACCUM collects beats, DRAIN presents result)
//   sint_max(w)    - bit pattern of the most positive w-bit two's-complement value
//   sint_min(w)    - bit pattern of the most negative w-bit two's-complement value
// Both helpers return the pattern in the low w bits of a 64-bit word (w in 2..64);
// callers truncate to their own width.
package sint_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic logic [63:0] sint_max(input int w);
        sint_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sint_min(input int w);
        sint_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sint_accumulator_if.sv
// sint_accumulator_if: sample stream in, frame result out.
//   in_valid/in_ready/in_data/in_last         - sample stream (producer -> accumulator)
//   out_valid/out_ready/out_sum/out_count/out_sat - frame result (accumulator -> consumer)
// master: the side that produces samples and consumes results (the environment).
// slave : the accumulator itself.
interface sint_accumulator_if #(
    parameter int WIDTH = 33,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_sum;
    logic        [CNT_W-1:0] out_count;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/sint_sat_adder.sv
// sint_sat_adder: combinational saturating adder for WIDTH-bit two's-complement values.
//   a, b   - signed operands
//   sum    - a+b clamped to [MIN, MAX] of WIDTH bits
//   clamp  - high when the true result was outside the representable range
module sint_sat_adder
    import sint_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    clamp
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(sint_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN = WIDTH'(sint_min(WIDTH));

    logic [WIDTH:0] wide;

    always_comb begin
        // One guard bit: the exact sum of two WIDTH-bit values always fits in WIDTH+1.
        wide  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        clamp = wide[WIDTH] ^ wide[WIDTH-1];
        if (!clamp) begin
            sum = wide[WIDTH-1:0];
        end else if (wide[WIDTH]) begin
            sum = MIN;      // true result negative: clamp to the bottom rail
        end else begin
            sum = MAX;
        end
    end
endmodule

// File: rtl/sint_accumulator.sv
// sint_accumulator: frame-based saturating accumulator.
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - slave side of sint_accumulator_if: samples in, per-frame
//            {sum, beat count, saturation flag} out
// Beats are summed with per-beat saturation while in ACCUM; the beat carrying
// in_last moves the block to DRAIN, where the result is held until out_ready.
// in_ready / out_valid come straight from the state register.
module sint_accumulator
    import sint_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    sint_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] sum_q, sum_d;
    logic        [CNT_W-1:0] count_q, count_d;
    logic                    sat_q, sat_d;

    logic signed [WIDTH-1:0] add_sum;
    logic                    add_clamp;
    logic                    accept;
    logic                    drained;

    sint_sat_adder #(
        .WIDTH (WIDTH)
    ) u_sat_adder (
        .a     (sum_q),
        .b     (bus.in_data),
        .sum   (add_sum),
        .clamp (add_clamp)
    );

    assign accept  = (state_q == ACCUM) && bus.in_valid;
    assign drained = (state_q == DRAIN) && bus.out_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (bus.in_valid && bus.in_last) state_d = DRAIN;
            DRAIN:   if (bus.out_ready)               state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Output decode: handshake strobes depend on the state register only.
    always_comb begin
        bus.in_ready  = (state_q == ACCUM);
        bus.out_valid = (state_q == DRAIN);
        bus.out_sum   = sum_q;
        bus.out_count = count_q;
        bus.out_sat   = sat_q;
    end

    // Datapath next values
    always_comb begin
        sum_d   = sum_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (accept) begin
            sum_d   = add_sum;
            // Counter sticks at all-ones rather than wrapping on long frames.
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
            sat_d   = sat_q | add_clamp;
        end else if (drained) begin
            sum_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end
endmodule
